// File: rtl/uart_rx_if.sv
// Host-side handshake of the UART receiver: received word, status flags and read acknowledge.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd_ack;
  logic [DATA_WIDTH-1:0] dout;
  logic                  data_valid;
  logic                  rx_done_tick;
  logic                  frame_err;
  logic                  overrun_err;
  logic                  rx_busy;

  modport master (
    output dout, data_valid, rx_done_tick, frame_err, overrun_err, rx_busy,
    input  rd_ack
  );

  modport slave (
    input  dout, data_valid, rx_done_tick, frame_err, overrun_err, rx_busy,
    output rd_ack
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing with a one-word holding register,
// valid/ack handshake, framing-error and sticky overrun flags.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic      clk,
  input  logic      reset_in,
  input  logic      rx,
  input  logic      s_tick,
  uart_rx_if.master host
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_WIDTH - 1);

  state_t                state_reg, state_next;
  logic [S_W-1:0]        s_reg, s_next;
  logic [N_W-1:0]        n_reg, n_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  done_reg, done_next;
  logic                  frame_err_reg, frame_err_next;
  logic                  overrun_reg, overrun_next;
  logic                  rx_meta_reg, rx_s_reg;
  logic                  frame_done;
  logic                  ack;

  // Two-flop synchronizer; resets to the idle-high line level so release cannot fake a start edge.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_reg      <= IDLE;
      s_reg          <= '0;
      n_reg          <= '0;
      shift_reg      <= '0;
      dout_reg       <= '0;
      data_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      s_reg          <= s_next;
      n_reg          <= n_next;
      shift_reg      <= shift_next;
      dout_reg       <= dout_next;
      data_valid_reg <= data_valid_next;
      done_reg       <= done_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    n_next     = n_reg;
    shift_next = shift_reg;
    frame_done = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next = START;
          s_next     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_reg == S_MID) begin
            // A line that is high again at mid start bit was a glitch: drop it silently.
            if (!rx_s_reg) begin
              state_next = DATA;
              s_next     = '0;
              n_next     = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_reg == S_BIT) begin
            shift_next = {rx_s_reg, shift_reg[DATA_WIDTH-1:1]};
            s_next     = '0;
            if (n_reg == N_LAST) begin
              state_next = STOP;
            end else begin
              n_next = n_reg + 1'b1;
            end
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_reg == S_STOP) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end else begin
            s_next = s_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // An ack landing on the completion cycle consumes the old word, so the new one is not an overrun.
  always_comb begin
    ack             = host.rd_ack & data_valid_reg;
    done_next       = frame_done;
    dout_next       = frame_done ? shift_reg : dout_reg;
    frame_err_next  = frame_done ? ~rx_s_reg : frame_err_reg;
    data_valid_next = frame_done ? 1'b1 : (ack ? 1'b0 : data_valid_reg);
    if (frame_done && data_valid_reg && !host.rd_ack) begin
      overrun_next = 1'b1;
    end else if (ack) begin
      overrun_next = 1'b0;
    end else begin
      overrun_next = overrun_reg;
    end
  end

  assign host.dout         = dout_reg;
  assign host.data_valid   = data_valid_reg;
  assign host.rx_done_tick = done_reg;
  assign host.frame_err    = frame_err_reg;
  assign host.overrun_err  = overrun_reg;
  assign host.rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean, framing-error, glitch, overrun, simultaneous-ack and reset cases.
module tb_uart_rx;
  localparam int DW = 8;
  localparam int OS = 16;

  logic clk = 1'b0;
  logic reset_in;
  logic rx;
  logic s_tick = 1'b0;
  int   tick_div = 4;
  int   tick_cnt = 0;

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic busy_at_done = 1'b1;
  logic prev_done = 1'b0;
  logic consec_seen = 1'b0;
  logic ack_hit;
  int   done_base;

  uart_rx_if #(.DATA_WIDTH(DW)) host ();

  uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS), .SB_TICK(16)) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .rx       (rx),
    .s_tick   (s_tick),
    .host     (host)
  );

  always #5 clk = ~clk;

  // s_tick changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (host.rx_done_tick) begin
      done_cnt     = done_cnt + 1;
      busy_at_done = host.rx_busy;
      if (prev_done) consec_seen = 1'b1;
    end
    prev_done = host.rx_done_tick;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (OS * tick_div) @(negedge clk);
  endtask

  // Bad stop: line low through the stop-bit sample point, then back high before the
  // restarted START would sample it, so no phantom frame follows.
  task automatic send_frame(input logic [DW-1:0] data, input logic bad_stop);
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(data[i]);
    if (bad_stop) begin
      rx = 1'b0;
      repeat (OS * tick_div * 5 / 8) @(negedge clk);
      rx = 1'b1;
      repeat (OS * tick_div * 3 / 8) @(negedge clk);
    end else begin
      drive_bit(1'b1);
    end
    drive_bit(1'b1);
  endtask

  task automatic pulse_ack();
    host.rd_ack = 1'b1;
    @(negedge clk);
    host.rd_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"},  32'(host.dout), 32'h0);
    check({tag, "_valid"}, 32'(host.data_valid), 32'h0);
    check({tag, "_done"},  32'(host.rx_done_tick), 32'h0);
    check({tag, "_ferr"},  32'(host.frame_err), 32'h0);
    check({tag, "_ovr"},   32'(host.overrun_err), 32'h0);
    check({tag, "_busy"},  32'(host.rx_busy), 32'h0);
  endtask

  initial begin
    reset_in    = 1'b0;
    rx          = 1'b1;
    host.rd_ack = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset_in = 1'b1;
    repeat (5) @(negedge clk);

    // Clean frame
    send_frame(8'hA5, 1'b0);
    check("a5_done_cnt", 32'(done_cnt), 32'd1);
    check("a5_dout", 32'(host.dout), 32'hA5);
    check("a5_valid", 32'(host.data_valid), 32'd1);
    check("a5_ferr", 32'(host.frame_err), 32'd0);
    check("a5_ovr", 32'(host.overrun_err), 32'd0);
    check("a5_busy_at_done", 32'(busy_at_done), 32'd0);
    pulse_ack();
    check("a5_ack_valid", 32'(host.data_valid), 32'd0);

    // Framing error, then good frame rewrites frame_err
    send_frame(8'h3C, 1'b1);
    check("3c_done_cnt", 32'(done_cnt), 32'd2);
    check("3c_dout", 32'(host.dout), 32'h3C);
    check("3c_ferr", 32'(host.frame_err), 32'd1);
    check("3c_valid", 32'(host.data_valid), 32'd1);
    pulse_ack();
    send_frame(8'h55, 1'b0);
    check("55_done_cnt", 32'(done_cnt), 32'd3);
    check("55_dout", 32'(host.dout), 32'h55);
    check("55_ferr", 32'(host.frame_err), 32'd0);
    pulse_ack();

    // Start glitch: 3 ticks low
    rx = 1'b0;
    repeat (3 * tick_div) @(negedge clk);
    check("gl_busy_mid", 32'(host.rx_busy), 32'd1);
    rx = 1'b1;
    repeat (2 * OS * tick_div) @(negedge clk);
    check("gl_busy_after", 32'(host.rx_busy), 32'd0);
    check("gl_done_cnt", 32'(done_cnt), 32'd3);
    check("gl_valid", 32'(host.data_valid), 32'd0);
    check("gl_dout", 32'(host.dout), 32'h55);
    check("gl_ferr", 32'(host.frame_err), 32'd0);
    send_frame(8'h81, 1'b0);
    check("81_dout", 32'(host.dout), 32'h81);
    check("81_done_cnt", 32'(done_cnt), 32'd4);
    pulse_ack();

    // Overrun
    send_frame(8'h11, 1'b0);
    check("ov1_ovr", 32'(host.overrun_err), 32'd0);
    send_frame(8'h22, 1'b0);
    check("ov_dout", 32'(host.dout), 32'h22);
    check("ov_ovr", 32'(host.overrun_err), 32'd1);
    check("ov_valid", 32'(host.data_valid), 32'd1);
    pulse_ack();
    check("ov_ack_valid", 32'(host.data_valid), 32'd0);
    check("ov_ack_ovr", 32'(host.overrun_err), 32'd0);

    // Simultaneous ack, fastest tick rate
    tick_div = 1;
    repeat (4) @(negedge clk);
    send_frame(8'h33, 1'b0);
    check("sa1_dout", 32'(host.dout), 32'h33);
    check("sa1_valid", 32'(host.data_valid), 32'd1);
    ack_hit = 1'b0;
    fork
      send_frame(8'h44, 1'b0);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (dut.state_reg == 2'd3 && dut.s_reg == 4'd15) begin
            host.rd_ack = 1'b1;
            @(negedge clk);
            host.rd_ack = 1'b0;
            ack_hit = 1'b1;
            break;
          end
        end
      end
    join
    check("sa_ack_hit", 32'(ack_hit), 32'd1);
    check("sa_dout", 32'(host.dout), 32'h44);
    check("sa_valid", 32'(host.data_valid), 32'd1);
    check("sa_ovr", 32'(host.overrun_err), 32'd0);

    // Reset in the middle of data bit 4 of 0xF0
    tick_div = 4;
    repeat (8) @(negedge clk);
    done_base = done_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    rx = 1'b1;
    repeat (OS * tick_div / 2) @(negedge clk);
    reset_in = 1'b0;
    #1;
    check_all_zero("mid");
    rx = 1'b1;
    repeat (4) @(negedge clk);
    reset_in = 1'b1;
    repeat (3 * OS * tick_div) @(negedge clk);
    check("mid_no_done", 32'(done_cnt), 32'(done_base));
    check("mid_busy", 32'(host.rx_busy), 32'd0);
    send_frame(8'h0F, 1'b0);
    check("0f_dout", 32'(host.dout), 32'h0F);
    check("0f_done_cnt", 32'(done_cnt), 32'(done_base + 1));
    check("0f_ferr", 32'(host.frame_err), 32'd0);
    check("no_consec_done", 32'(consec_seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver core and the counterpart of the team's uart_tx.
- Oversamples the serial line using the shared baud tick (s_tick, OVERSAMPLE ticks per bit).
- Validates the start bit at mid-bit, shifts in DATA_WIDTH data bits LSB-first and checks the stop bit.
- Presents each received word in a one-entry holding register with valid/ack handshake, framing-error flag and overrun flag.
- Sits between the pad-side rx line and the host/FIFO logic; shares the baud generator with uart_tx.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, s_tick pulses per bit period (even, >=8)
SB_TICK, 16, s_tick pulses spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock, rising edge
reset_in  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
s_tick  input  1  one-clk baud oversample strobe
rd_ack  input  1  consumer has taken dout; clears data_valid
dout  output  DATA_WIDTH  last received data word
data_valid  output  1  dout holds an unread word
rx_done_tick  output  1  one-clk pulse per completed frame
frame_err  output  1  stop bit of the word in dout sampled low
overrun_err  output  1  sticky: a completed frame overwrote an unread word
rx_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: reset_in is asynchronous, active-low; clock is clk. While low, all of the following hold:
  - state=IDLE; s counter, n counter, shift register and dout = 0.
  - data_valid, rx_done_tick, frame_err, overrun_err, rx_busy = 0.
  - Both synchronizer flops = 1.
- Reset mid-frame aborts the frame silently. After release the receiver waits in IDLE for a falling edge.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, which adds 2 clk of latency.
- States: IDLE, START, DATA, STOP. The s and n counters advance only on clk edges where s_tick=1.
- IDLE:
  - rx_s=0 -> START, s=0. s_tick is not required for this transition.
- START:
  - On s_tick with s==OVERSAMPLE/2-1, sample rx_s:
    - rx_s=0 -> DATA, s=0, n=0.
    - rx_s=1 -> IDLE. This is a glitch: no flags are set and no pulse is issued.
  - Otherwise s++ on s_tick.
- DATA:
  - On s_tick with s==OVERSAMPLE-1: shift = {rx_s, shift[DATA_WIDTH-1:1]} (LSB first) and s=0.
    - If n==DATA_WIDTH-1 -> STOP; otherwise n++.
  - Otherwise s++ on s_tick.
- STOP:
  - On s_tick with s==SB_TICK-1, the following all take effect on the same clk edge:
    - dout <= shift.
    - frame_err <= ~rx_s.
    - rx_done_tick <= 1 for exactly one clk.
    - data_valid <= 1.
    - state <= IDLE.
  - Otherwise s++ on s_tick.
- A frame with a bad stop bit is still delivered, with frame_err=1.
- frame_err describes the word currently in dout and is rewritten on every frame.
- Break condition (rx held low): the frame completes with frame_err=1, then rx_s=0 in IDLE starts a new START immediately. The START mid-bit check passes, so back-to-back error frames follow. This is the required behaviour.
- Handshake: rd_ack clears data_valid on the next edge.
- rd_ack with data_valid=0 is ignored.
- Overrun:
  - A frame completes while data_valid=1 and rd_ack=0 -> overrun_err <= 1 and dout is overwritten with the new word.
  - A frame completes in the same cycle as rd_ack -> data_valid stays 1 and there is no overrun.
- overrun_err stays set until an rd_ack in a cycle that is not itself an overrun.
- rx_done_tick never asserts on consecutive clk cycles.
- Latency: the rx falling edge is detected in IDLE 2 clk later, and the mid-start-bit sample is taken OVERSAMPLE/2 ticks after that.
- s_tick asserted every clk is legal and must work; the bench uses this as the fastest case.

Test Plan:
- Clean frame: s_tick every 4 clk, OVERSAMPLE=16, send 0xA5 (line order 1,0,1,0,0,1,0,1) with a good stop bit -> one rx_done_tick, dout=0xA5, data_valid=1, frame_err=0, rx_busy falls the same cycle.
- Framing error: send 0x3C with the stop bit driven low -> dout=0x3C, frame_err=1, data_valid=1. A following good frame 0x55 -> frame_err=0, dout=0x55.
- Start glitch: rx low for 3 ticks then high -> state returns to IDLE, no rx_done_tick, all flags unchanged. A valid 0x81 sent afterwards is received correctly.
- Overrun: two frames (0x11, 0x22) with no rd_ack -> dout=0x22, overrun_err=1. Then rd_ack -> data_valid=0, overrun_err=0.
- Simultaneous ack: rd_ack pulsed in the exact cycle the second frame completes -> data_valid=1, dout=new word, overrun_err=0.
- Reset mid-frame: drop reset_in during DATA bit 4 of 0xF0 -> all outputs 0 asynchronously. After release with rx idle, no spurious rx_done_tick; the next frame 0x0F is received correctly.
